button_debouncer: RTL

- Upstream conditioning stage for the LED shifter.
- Takes raw, asynchronous, bouncing push-button pins and produces clean, synchronised per-button level outputs.
- Also produces single-cycle rising-edge (press) and falling-edge (release) pulses.
- buttons_re[1:0] drives the shifter's button0_re/button1_re inputs directly.

---
 rtl/button_debouncer.sv | 100 ++++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// Debounces raw, asynchronous push-button pins into clean pressed levels plus
// single-cycle press/release pulses, one fully independent channel per button.
module button_debouncer #(
    parameter int NUM_BUTTONS     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                   clk,
    input  logic                   async_nreset,
    input  logic [NUM_BUTTONS-1:0] buttons_in,
    output logic [NUM_BUTTONS-1:0] buttons_level,
    output logic [NUM_BUTTONS-1:0] buttons_re,
    output logic [NUM_BUTTONS-1:0] buttons_fe
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REL,
        PEND_P,
        PRS,
        PEND_R
    } state_t;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        logic [1:0]    sync_q;
        state_t        state_q;
        logic [CW-1:0] cnt_q;
        logic          level_q;
        logic          re_q;
        logic          fe_q;
        logic          pressed;

        // Synchroniser resets to the released pin level so reset exit looks idle.
        assign pressed = sync_q[1] ^ ACTIVE_LOW;

        always_ff @(posedge clk or negedge async_nreset) begin
            if (!async_nreset) begin
                sync_q  <= {2{ACTIVE_LOW}};
                state_q <= REL;
                cnt_q   <= '0;
                level_q <= 1'b0;
                re_q    <= 1'b0;
                fe_q    <= 1'b0;
            end else begin
                sync_q <= {sync_q[0], buttons_in[i]};
                re_q   <= 1'b0;
                fe_q   <= 1'b0;
                case (state_q)
                    REL: begin
                        if (pressed) begin
                            state_q <= PEND_P;
                            cnt_q   <= '0;
                        end
                    end
                    PEND_P: begin
                        if (!pressed) begin
                            state_q <= REL;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= PRS;
                            level_q <= 1'b1;
                            re_q    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    PRS: begin
                        if (!pressed) begin
                            state_q <= PEND_R;
                            cnt_q   <= '0;
                        end
                    end
                    PEND_R: begin
                        if (pressed) begin
                            state_q <= PRS;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= REL;
                            level_q <= 1'b0;
                            fe_q    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q <= REL;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign buttons_level[i] = level_q;
        assign buttons_re[i]    = re_q;
        assign buttons_fe[i]    = fe_q;
    end

endmodule
